// File: rtl/prio_enc_drain.sv
// Sequential priority encoder: accepts a request vector, then reports each set bit
// highest-first, one per output beat. Optional flush input via PRIO_ENC_DRAIN_FLUSH_EN.
module prio_enc_drain #(
   parameter  int WIDTH = 16,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
`ifdef PRIO_ENC_DRAIN_FLUSH_EN
   input  logic             flush,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             busy
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   pend_q, pend_d;
   logic               out_valid_q, out_valid_d;
   logic [IDX_W-1:0]   out_idx_q, out_idx_d;
   logic               out_last_q, out_last_d;
   logic               flush_req;

`ifdef PRIO_ENC_DRAIN_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q == DRAIN);

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               pend_d  = in_vec;
               state_d = (in_vec != '0) ? DRAIN : IDLE;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               pend_d = pend_q & ~(ONE << out_idx_q);
               if (out_last_q) state_d = IDLE;
            end
            // A beat completing on the flush edge is still delivered; only the rest is dropped.
            if (flush_req) begin
               pend_d  = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            pend_d  = '0;
         end
      endcase
   end

   // Next beat is precomputed from the next pending vector so outputs come straight from flops.
   always_comb begin
      out_idx_d = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (pend_d[i]) out_idx_d = IDX_W'(i);
      end
      out_last_d  = (pend_d != '0) && ((pend_d & (pend_d - ONE)) == '0);
      out_valid_d = (state_d == DRAIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pend_q      <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
      end
   end

endmodule

// File: tb/tb_prio_enc_drain.sv
// Self-checking bench for prio_enc_drain: WIDTH=16 table/scoreboard run plus a WIDTH=40 instance.
module tb_prio_enc_drain;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        in_valid16 = 1'b0, out_ready16 = 1'b0;
   logic [15:0] in_vec16 = '0;
   logic        in_ready16, out_valid16, out_last16, busy16;
   logic [3:0]  out_idx16;

   logic        in_valid40 = 1'b0, out_ready40 = 1'b0;
   logic [39:0] in_vec40 = '0;
   logic        in_ready40, out_valid40, out_last40, busy40;
   logic [5:0]  out_idx40;
`ifdef PRIO_ENC_DRAIN_FLUSH_EN
   logic        flush16 = 1'b0, flush40 = 1'b0;
`endif

   prio_enc_drain #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst),
`ifdef PRIO_ENC_DRAIN_FLUSH_EN
      .flush(flush16),
`endif
      .in_valid(in_valid16), .in_ready(in_ready16), .in_vec(in_vec16),
      .out_valid(out_valid16), .out_ready(out_ready16), .out_idx(out_idx16),
      .out_last(out_last16), .busy(busy16)
   );

   prio_enc_drain #(.WIDTH(40)) u_dut40 (
      .clk(clk), .rst(rst),
`ifdef PRIO_ENC_DRAIN_FLUSH_EN
      .flush(flush40),
`endif
      .in_valid(in_valid40), .in_ready(in_ready40), .in_vec(in_vec40),
      .out_valid(out_valid40), .out_ready(out_ready40), .out_idx(out_idx40),
      .out_last(out_last40), .busy(busy40)
   );

   typedef struct {int idx; bit last;} beat_t;
   typedef struct {logic [15:0] vec; int nbeats; int first_idx;} vec_t;

   beat_t q[$];
   int checks = 0;
   int errors = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send16(input logic [15:0] v);
      int w;
      logic [15:0] lo;
      beat_t b;
      w = 0;
      while (!in_ready16 && w < 20) begin
         step();
         w++;
      end
      chk("in_ready_wait", in_ready16, 1);
      in_valid16 = 1'b1;
      in_vec16   = v;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) begin
            lo     = v & ((16'd1 << i) - 16'd1);
            b.idx  = i;
            b.last = (lo == '0);
            q.push_back(b);
         end
      end
      step();
      in_valid16 = 1'b0;
      in_vec16   = 16'($urandom);
   endtask

   task automatic drain16(input int max_beats, output int n);
      beat_t b;
      int k;
      n = 0;
      k = 0;
      while (q.size() > 0 && k < max_beats) begin
         out_ready16 = 1'b1;
         chk("beat_valid", out_valid16, 1);
         chk("no_overlap_in_ready", in_ready16, 0);
         b = q.pop_front();
         chk("beat_idx", out_idx16, b.idx);
         chk("beat_last", out_last16, b.last);
         if (out_valid16) n++;
         k++;
         step();
      end
      out_ready16 = 1'b0;
      if (q.size() == 0) begin
         chk("idle_valid", out_valid16, 0);
         chk("idle_in_ready", in_ready16, 1);
         chk("idle_busy", busy16, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv[6];
      int n;
      int exp40 [3];

      tv[0] = '{16'h8421, 4, 15};
      tv[1] = '{16'h0000, 0, 0};
      tv[2] = '{16'h0001, 1, 0};
      tv[3] = '{16'hFFFF, 16, 15};
      tv[4] = '{16'h5A00, 4, 14};
      tv[5] = '{16'h8000, 1, 15};

      // reset
      #1;
      chk("rst_in_ready", in_ready16, 0);
      step();
      step();
      chk("rst_in_ready2", in_ready16, 0);
      chk("rst_valid", out_valid16, 0);
      chk("rst_busy", busy16, 0);
      chk("rst_idx", out_idx16, 0);
      chk("rst_last", out_last16, 0);
      chk("rst_valid40", out_valid40, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready16, 1);
      chk("post_rst_in_ready40", in_ready40, 1);

      for (int k = 0; k < 6; k++) begin
         out_ready16 = 1'b1;
         send16(tv[k].vec);
         if (tv[k].nbeats == 0) begin
            chk("zero_valid", out_valid16, 0);
            chk("zero_in_ready", in_ready16, 1);
            chk("zero_busy", busy16, 0);
         end else begin
            chk("first_idx", out_idx16, tv[k].first_idx);
            chk("first_busy", busy16, 1);
         end
         drain16(100, n);
         chk("beat_count", n, tv[k].nbeats);
      end

      // stall with garbage offered on the input side
      send16(16'h00C0);
      out_ready16 = 1'b0;
      in_valid16  = 1'b1;
      in_vec16    = 16'hFFFF;
      for (int c = 0; c < 3; c++) begin
         chk("stall_valid", out_valid16, 1);
         chk("stall_idx", out_idx16, 7);
         chk("stall_last", out_last16, 0);
         chk("stall_busy", busy16, 1);
         step();
      end
      in_valid16 = 1'b0;
      drain16(100, n);
      chk("stall_beats", n, 2);

      // reset mid-drain
      send16(16'hFFFF);
      drain16(5, n);
      chk("pre_rst_beats", n, 5);
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", in_ready16, 0);
      step();
      rst = 1'b0;
      chk("mid_rst_valid", out_valid16, 0);
      chk("mid_rst_busy", busy16, 0);
      chk("mid_rst_idx", out_idx16, 0);
      q.delete();
      out_ready16 = 1'b1;
      for (int c = 0; c < 3; c++) begin
         chk("post_rst_quiet", out_valid16, 0);
         step();
      end
      send16(16'h0010);
      drain16(100, n);
      chk("post_rst_beats", n, 1);

      // WIDTH=40
      exp40[0] = 39;
      exp40[1] = 32;
      exp40[2] = 1;
      in_valid40 = 1'b1;
      in_vec40   = 40'h81_0000_0002;
      step();
      in_valid40  = 1'b0;
      out_ready40 = 1'b1;
      for (int j = 0; j < 3; j++) begin
         chk("w40_valid", out_valid40, 1);
         chk("w40_idx", out_idx40, exp40[j]);
         chk("w40_last", out_last40, (j == 2));
         step();
      end
      chk("w40_idle_valid", out_valid40, 0);
      chk("w40_idle_in_ready", in_ready40, 1);

`ifdef PRIO_ENC_DRAIN_FLUSH_EN
      in_valid40 = 1'b1;
      in_vec40   = 40'h81_0000_0002;
      step();
      in_valid40 = 1'b0;
      chk("fl_idx39", out_idx40, 39);
      step();
      chk("fl_idx32", out_idx40, 32);
      flush40 = 1'b1;
      step();
      flush40 = 1'b0;
      chk("fl_valid", out_valid40, 0);
      chk("fl_busy", busy40, 0);
      chk("fl_in_ready", in_ready40, 1);
      for (int c = 0; c < 3; c++) begin
         chk("fl_quiet", out_valid40, 0);
         step();
      end
      flush40    = 1'b1;
      in_valid40 = 1'b1;
      in_vec40   = 40'h4;
      step();
      flush40    = 1'b0;
      in_valid40 = 1'b0;
      chk("fl_idle_valid", out_valid40, 1);
      chk("fl_idle_idx", out_idx40, 2);
      chk("fl_idle_last", out_last40, 1);
      step();
      chk("fl_idle_done", out_valid40, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
